// File: rtl/ysyx_210247_trap_seq_pkg.sv
// Shared constants and types for the trap sequencer: op codes, mcause values,
// mstatus field positions, FSM encoding and the register bus width.
package ysyx_210247_trap_seq_pkg;

    localparam int unsigned REG_BUS     = 64;
    localparam int unsigned DRAIN_CNT_W = 8;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_ECALL = 2'b01,
        OP_MRET  = 2'b10,
        OP_IRQ   = 2'b11
    } trap_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_DRAIN    = 2'b01,
        ST_UPDATE   = 2'b10,
        ST_REDIRECT = 2'b11
    } state_e;

    localparam logic [REG_BUS-1:0] MCAUSE_ECALL = 64'd11;
    localparam logic [REG_BUS-1:0] MCAUSE_TIMER = 64'h8000_0000_0000_0007;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

    // mstatus after trap entry (ecall/interrupt) or trap return (mret).
    function automatic logic [REG_BUS-1:0] mstatus_next(input trap_op_e op,
                                                        input logic [REG_BUS-1:0] cur);
        logic [REG_BUS-1:0] r;
        r = cur;
        if (op == OP_MRET) begin
            r[MSTATUS_MIE]  = cur[MSTATUS_MPIE];
            r[MSTATUS_MPIE] = 1'b1;
        end else begin
            r[MSTATUS_MPIE] = cur[MSTATUS_MIE];
            r[MSTATUS_MIE]  = 1'b0;
        end
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

endpackage

// File: rtl/ysyx_210247_trap_seq.sv
// Trap sequencer: accepts an ecall/mret/interrupt from commit, drains the bus,
// writes the machine CSRs for one cycle, then redirects and flushes the pipe.
module ysyx_210247_trap_seq
    import ysyx_210247_trap_seq_pkg::*;
#(
    parameter logic [DRAIN_CNT_W-1:0] DRAIN_MAX = 8'd255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trap_valid,
    input  logic [1:0]         trap_op,
    input  logic [REG_BUS-1:0] trap_pc,
    output logic               trap_ready,
    input  logic               bus_busy,
    input  logic [REG_BUS-1:0] csr_mtvec,
    input  logic [REG_BUS-1:0] csr_mepc,
    input  logic [REG_BUS-1:0] csr_mstatus,
    output logic               csr_mepc_wen,
    output logic               csr_mcause_wen,
    output logic               csr_mstatus_wen,
    output logic [REG_BUS-1:0] csr_mepc_wdata,
    output logic [REG_BUS-1:0] csr_mcause_wdata,
    output logic [REG_BUS-1:0] csr_mstatus_wdata,
    output logic               stall,
    output logic               flush,
    output logic               redirect_valid,
    output logic [REG_BUS-1:0] redirect_pc,
    output logic               drain_timeout
);

    state_e                   state_q, state_d;
    trap_op_e                 op_q, op_d;
    logic [REG_BUS-1:0]       pc_q, pc_d;
    logic [DRAIN_CNT_W-1:0]   cnt_q, cnt_d;
    logic                     timeout_q, timeout_d;
    logic [REG_BUS-1:0]       redirect_pc_q, redirect_pc_d;

    logic                     run_c;
    logic                     accept_c;
    logic                     in_update_c;
    logic                     in_redirect_c;
    logic [DRAIN_CNT_W-1:0]   cnt_inc_c;
    logic                     unused_ok_c;

    // Everything visible is forced low while reset is asserted.
    assign run_c         = ~rst;
    assign accept_c      = run_c && (state_q == ST_IDLE) && trap_valid && (trap_op != OP_NONE);
    assign in_update_c   = run_c && (state_q == ST_UPDATE);
    assign in_redirect_c = run_c && (state_q == ST_REDIRECT);
    assign cnt_inc_c     = cnt_q + DRAIN_CNT_W'(1);
    assign unused_ok_c   = ^{csr_mtvec[1:0], pc_q[1:0]};

    // State and latched-event registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_NONE;
            pc_q          <= '0;
            cnt_q         <= '0;
            timeout_q     <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            pc_q          <= pc_d;
            cnt_q         <= cnt_d;
            timeout_q     <= timeout_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    // Next-state logic: IDLE -> DRAIN -> UPDATE -> REDIRECT -> IDLE.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        pc_d          = pc_q;
        cnt_d         = cnt_q;
        timeout_d     = timeout_q;
        redirect_pc_d = redirect_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    op_d    = trap_op_e'(trap_op);
                    pc_d    = trap_pc;
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!bus_busy) begin
                    state_d = ST_UPDATE;
                end else begin
                    cnt_d = cnt_inc_c;
                    // A bus that never goes idle must not wedge the trap path.
                    if (cnt_inc_c == DRAIN_MAX) begin
                        state_d   = ST_UPDATE;
                        timeout_d = 1'b1;
                    end
                end
            end
            ST_UPDATE: begin
                redirect_pc_d = (op_q == OP_MRET) ? csr_mepc : {csr_mtvec[REG_BUS-1:2], 2'b00};
                state_d       = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the state register.
    assign trap_ready        = run_c && (state_q == ST_IDLE);
    assign stall             = run_c && (state_q != ST_IDLE);
    assign csr_mstatus_wen   = in_update_c;
    assign csr_mepc_wen      = in_update_c && (op_q != OP_MRET);
    assign csr_mcause_wen    = in_update_c && (op_q != OP_MRET);
    assign csr_mepc_wdata    = run_c ? {pc_q[REG_BUS-1:2], 2'b00} : '0;
    assign csr_mcause_wdata  = !run_c            ? '0 :
                               (op_q == OP_IRQ)   ? MCAUSE_TIMER :
                               (op_q == OP_ECALL) ? MCAUSE_ECALL : '0;
    assign csr_mstatus_wdata = in_update_c ? mstatus_next(op_q, csr_mstatus) : '0;
    assign redirect_valid    = in_redirect_c;
    assign flush             = in_redirect_c;
    assign redirect_pc       = run_c ? redirect_pc_q : '0;
    assign drain_timeout     = run_c && timeout_q;

endmodule

// File: doc/ysyx_210247_trap_seq.md
YSYX_210247_TRAP_SEQ -- requirements
Module: ysyx_210247_trap_seq

Interface
REQ-001 SHALL have parameter DRAIN_MAX, default 8'd255, meaning maximum DRAIN cycles before a forced exit.
REQ-002 SHALL have port clk  in  1  the single clock.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port trap_valid  in  1  commit stage presents a trap event.
REQ-005 SHALL have port trap_op  in  2  01 ecall, 10 mret, 11 timer interrupt, 00 none.
REQ-006 SHALL have port trap_pc  in  64  PC of the trapping instruction.
REQ-007 SHALL have port trap_ready  out  1  sequencer can accept an event.
REQ-008 SHALL have port bus_busy  in  1  AXI fetch/mem transaction outstanding.
REQ-009 SHALL have ports csr_mtvec, csr_mepc, csr_mstatus  in  64 each  current CSR values.
REQ-010 SHALL have ports csr_mepc_wen, csr_mcause_wen, csr_mstatus_wen  out  1 each  CSR write strobes.
REQ-011 SHALL have ports csr_mepc_wdata, csr_mcause_wdata, csr_mstatus_wdata  out  64 each  CSR write data.
REQ-012 SHALL have ports stall  out  1  (hold front end) and flush  out  1  (kill IF/ID/EX).
REQ-013 SHALL have ports redirect_valid  out  1  and redirect_pc  out  64  (PC redirect).
REQ-014 SHALL have port drain_timeout  out  1  sticky error flag.

Function
REQ-015 SHALL implement FSM IDLE -> DRAIN -> UPDATE -> REDIRECT -> IDLE.
REQ-016 SHALL drive trap_ready=1 only in IDLE, and SHALL accept an event when trap_valid & trap_ready & trap_op!=00, latching trap_op and trap_pc.
REQ-017 SHALL ignore trap_valid when trap_op==00: no state change, trap_ready stays 1.
REQ-018 SHALL hold stall=1 in DRAIN, UPDATE and REDIRECT, and 0 in IDLE.
REQ-019 SHALL leave DRAIN on the first cycle bus_busy==0, or when the 8-bit drain counter reaches DRAIN_MAX; the forced exit SHALL also set drain_timeout.
REQ-020 SHALL pulse the CSR strobes for exactly one cycle, in UPDATE:
  - ecall/interrupt: all three strobes asserted.
  - mret: only csr_mstatus_wen asserted.
REQ-021 SHALL set csr_mepc_wdata = {latched_pc[63:2], 2'b00}.
REQ-022 SHALL set csr_mcause_wdata = 64'd11 for ecall and 64'h8000_0000_0000_0007 for interrupt.
REQ-023 SHALL compute csr_mstatus_wdata from csr_mstatus sampled in UPDATE:
  - ecall/interrupt: MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]=2'b11.
  - mret: MIE[3]=MPIE[7], MPIE[7]=1, MPP=2'b11.
  - all other bits unchanged.
REQ-024 SHALL register redirect_pc in UPDATE: {csr_mtvec[63:2], 2'b00} for ecall/interrupt, csr_mepc for mret.
REQ-025 SHALL assert redirect_valid and flush for exactly one cycle, in REDIRECT, with redirect_pc stable that cycle.
REQ-026 SHALL give latency: accept at cycle T with bus_busy=0 -> UPDATE at T+2, redirect_valid at T+3, trap_ready again at T+4.
REQ-027 SHALL not accept a new event before returning to IDLE; a trap_valid held during the sequence is accepted only at T+4.
REQ-028 SHALL not assert any CSR strobe or redirect_valid outside UPDATE and REDIRECT respectively.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, enter IDLE and clear the latched op/pc, drain counter, drain_timeout, redirect_pc and all strobes, from any state.
REQ-030 SHALL, when reset occurs mid-sequence, issue no CSR write or redirect for the aborted event.
REQ-031 SHALL drive every output to 0 during reset except trap_ready, which SHALL be 0 while rst=1 and 1 the cycle after.

Structure
REQ-032 SHALL take the following from the shared defines.v: trap_op codes, mcause constants, mstatus bit positions (MIE, MPIE, MPP), FSM state encoding, and REG_BUS.
REQ-033 SHALL be a single module; the drain counter is inline and no sub-module is required.

Verification
REQ-034 SHALL cover ecall: trap_pc=64'h8000_0010, mtvec=64'h8000_1001, bus_busy=0 -> at T+2 mepc_wdata=64'h8000_0010, mcause_wdata=11; at T+3 redirect_pc=64'h8000_1000.
REQ-035 SHALL cover mret: mstatus=64'h80 and mepc=64'h8000_0014 -> mstatus_wdata=64'h1888, mepc_wen=0, redirect_pc=64'h8000_0014.
REQ-036 SHALL cover the interrupt drain: bus_busy high for 5 cycles after accept -> UPDATE exactly 1 cycle after bus_busy falls, mcause_wdata=64'h8000_0000_0000_0007, drain_timeout=0.
REQ-037 SHALL cover timeout: bus_busy stuck at 1 -> DRAIN exits after 255 cycles, drain_timeout=1 and stays 1 until rst.
REQ-038 SHALL cover reset mid-sequence: rst pulsed in UPDATE -> no redirect_valid, trap_ready=1 the cycle after rst falls.
REQ-039 SHALL cover back-to-back events: trap_valid held through a sequence -> second accept at T+4, and trap_op=00 never accepted.
